sfir_tap_sequencer: RTL and testbench
=====================================

Name: sfir_tap_sequencer

Overview:
- Read-side counterpart of the register delay line feeding the systolic FIR.
- Accepts one input sample per handshake and stores the last nbtap samples in a circular buffer.
- For each accepted sample, plays the taps x[n], x[n-1] … x[n-nbtap+1] out serially to a time-multiplexed MAC over a valid/ready stream.
- Sits between the sample source and a single shared multiplier-accumulator.

Parameters:
dsize, 16, sample width in bits
nbtap, 4, number of taps per sequence and circular buffer depth (>=2, any integer, not restricted to powers of two)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
datain  input  dsize  input sample
din_valid  input  1  datain valid
din_ready  output  1  block can accept a sample
tap_data  output  dsize  tap sample to MAC
tap_idx  output  clog2(nbtap)  tap index k of tap_data (x[n-k])
tap_valid  output  1  tap_data/tap_idx/tap_last valid
tap_ready  input  1  MAC accepts tap
tap_last  output  1  final tap of current sequence
busy  output  1  sequence in progress

Behaviour:
- Reset (async assert, sync release) clears:
  - wr_ptr, rd_ptr, fill counter, all buffer words
  - tap_data=0, tap_idx=0, tap_valid=0, tap_last=0, busy=0
  - state=IDLE; din_ready=1 one cycle after release.
- FSM states:
  - IDLE: din_ready=1. Sample accept (din_valid&din_ready) at edge t: write buf[wr_ptr]=datain; fill=min(fill+1,nbtap); rd_ptr=wr_ptr; wr_ptr advances with wrap nbtap-1->0; go SEQ.
  - SEQ: din_ready=0, busy=1. Register slice presents tap k: tap_valid=1, tap_idx=k, tap_data=buf[(newest-k) mod nbtap] if k<fill, else 0.
- Latency: first tap (k=0, the new sample itself) valid at edge t+1.
- Tap stepping: on tap_valid&tap_ready, k increments on the next edge. tap_data, tap_idx and tap_last are held stable while tap_valid=1 and tap_ready=0.
- tap_last=1 exactly when k=nbtap-1. Acceptance of the last tap returns the FSM to IDLE: tap_valid=0, busy=0, din_ready=1 on the following edge.
- No back-to-back overlap: minimum nbtap+1 cycles per input sample at tap_ready=1 throughout.
- din_valid while din_ready=0: ignored, sample not written. The source must hold the sample per standard valid/ready.
- Zero padding: until nbtap samples have been received, taps with k>=fill read 0. Stale buffer contents are never emitted.
- Read pointer wraps modulo nbtap, including for non-power-of-two nbtap. Index arithmetic uses explicit compare-and-wrap, not a bit-width truncation.
- Reset asserted mid-sequence: outputs go to reset values immediately and buffer contents are lost. The partial sequence is never completed.
- tap_ready may be high when tap_valid=0; it has no effect in that case.

Optional Feature:
- Macro: SFIR_TAP_REVERSE_EN
- Defined: sequence order reversed, oldest first. tap_idx runs nbtap-1 down to 0 and tap_last=1 when tap_idx=0. The first tap of the sequence is x[n-nbtap+1], which is 0 when fill<nbtap.
- Undefined: newest first, tap_idx 0 up to nbtap-1, as specified above.
- All other timing and handshake behaviour is identical in both builds.

Test Plan:
- Reset then first sample 16'h0011, tap_ready=1, nbtap=4 -> taps (idx,data) = (0,0011),(1,0000),(2,0000),(3,0000) at t+1..t+4; tap_last only on idx 3; din_ready returns 1 at t+5.
- Samples 1,2,3,4,5 fed as fast as din_ready allows -> sequence after sample 5 = 5,4,3,2. Confirms wrap of wr_ptr and that sample 1 has been overwritten.
- tap_ready low for 3 cycles on idx 1 during sequence 10,20,30,40 -> tap_data=30, tap_idx=1 held stable for all 3 cycles, then sequence resumes; no tap skipped or duplicated.
- din_valid held high with changing datain during SEQ -> no buffer write. Only the value present when din_ready=1 is captured, checked in the next sequence.
- rst_n pulsed low at idx 2 of a sequence -> tap_valid, busy and tap_last are 0 asynchronously. The next sample 16'h00AA yields AA,0,0,0.
- Build with SFIR_TAP_REVERSE_EN, after samples 1..4 -> taps (3,1),(2,2),(1,3),(0,4); tap_last on idx 0.

Source files
------------

// File: rtl/sfir_tap_sequencer.sv
// Tap sequencer for a time-multiplexed FIR MAC: keeps the last nbtap samples in a
// circular buffer and streams x[n]..x[n-nbtap+1] per accepted sample.
// Optional build macro SFIR_TAP_REVERSE_EN streams oldest tap first instead.
module sfir_tap_sequencer #(
    parameter int dsize = 16,
    parameter int nbtap = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [dsize-1:0]         datain,
    input  logic                     din_valid,
    output logic                     din_ready,
    output logic [dsize-1:0]         tap_data,
    output logic [$clog2(nbtap)-1:0] tap_idx,
    output logic                     tap_valid,
    input  logic                     tap_ready,
    output logic                     tap_last,
    output logic                     busy
);

    localparam int IW = $clog2(nbtap);
    localparam int FW = $clog2(nbtap + 1);
    localparam logic [IW-1:0] NB_M1    = IW'(nbtap - 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(nbtap);

`ifdef SFIR_TAP_REVERSE_EN
    localparam logic [IW-1:0] FIRST_K = NB_M1;
    localparam logic [IW-1:0] LAST_K  = {IW{1'b0}};
`else
    localparam logic [IW-1:0] FIRST_K = {IW{1'b0}};
    localparam logic [IW-1:0] LAST_K  = NB_M1;
`endif

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEQ  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [dsize-1:0]     buf_q [nbtap];
    logic [IW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [IW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]        fill_q, fill_d;
    logic [dsize-1:0]     tap_data_q, tap_data_d;
    logic [IW-1:0]        tap_idx_q, tap_idx_d;
    logic                 tap_valid_q, tap_valid_d;
    logic                 tap_last_q, tap_last_d;
    logic                 busy_q, busy_d;
    logic                 din_ready_q, din_ready_d;

    logic                 accept_s;
    logic                 wr_en_s;
    logic [FW-1:0]        fill_inc_s;
    logic [IW-1:0]        next_k_s;
    logic [IW-1:0]        rd_newest_s;
    logic [FW-1:0]        rd_fill_s;
    logic [IW-1:0]        rd_addr_s;
    logic [dsize-1:0]     rd_data_s;

    // (newest - k) mod nbtap without relying on power-of-two truncation
    function automatic logic [IW-1:0] tap_addr(input logic [IW-1:0] newest,
                                               input logic [IW-1:0] k);
        logic [IW:0] sum;
        if (newest >= k) begin
            sum = {1'b0, newest} - {1'b0, k};
        end else begin
            sum = {1'b0, newest} + (IW+1)'(nbtap) - {1'b0, k};
        end
        return sum[IW-1:0];
    endfunction

    function automatic logic [IW-1:0] step_k(input logic [IW-1:0] k);
`ifdef SFIR_TAP_REVERSE_EN
        return k - IW'(1);
`else
        return k + IW'(1);
`endif
    endfunction

    // Read path: data for the tap presented on the next edge
    always_comb begin
        accept_s    = (state_q == ST_IDLE) && din_valid && din_ready_q;
        fill_inc_s  = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + FW'(1);
        next_k_s    = step_k(tap_idx_q);
        rd_newest_s = rd_ptr_q;
        rd_fill_s   = fill_q;
        rd_data_s   = {dsize{1'b0}};
        if (accept_s) begin
            next_k_s    = FIRST_K;
            rd_newest_s = wr_ptr_q;
            rd_fill_s   = fill_inc_s;
        end else begin
            next_k_s    = step_k(tap_idx_q);
        end
        rd_addr_s = tap_addr(rd_newest_s, next_k_s);
        // Slots beyond the fill level are zero-padded; the word being written bypasses
        if (FW'(next_k_s) < rd_fill_s) begin
            if (accept_s && (rd_addr_s == wr_ptr_q)) begin
                rd_data_s = datain;
            end else begin
                rd_data_s = buf_q[rd_addr_s];
            end
        end else begin
            rd_data_s = {dsize{1'b0}};
        end
    end

    // Sequencer next-state and registered-output next values
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fill_d      = fill_q;
        tap_data_d  = tap_data_q;
        tap_idx_d   = tap_idx_q;
        tap_valid_d = tap_valid_q;
        tap_last_d  = tap_last_q;
        busy_d      = busy_q;
        din_ready_d = din_ready_q;
        wr_en_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                din_ready_d = 1'b1;
                busy_d      = 1'b0;
                if (accept_s) begin
                    wr_en_s     = 1'b1;
                    wr_ptr_d    = (wr_ptr_q == NB_M1) ? {IW{1'b0}} : wr_ptr_q + IW'(1);
                    rd_ptr_d    = wr_ptr_q;
                    fill_d      = fill_inc_s;
                    state_d     = ST_SEQ;
                    din_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    tap_valid_d = 1'b1;
                    tap_idx_d   = next_k_s;
                    tap_data_d  = rd_data_s;
                    tap_last_d  = (next_k_s == LAST_K);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEQ: begin
                if (tap_valid_q && tap_ready) begin
                    if (tap_last_q) begin
                        state_d     = ST_IDLE;
                        tap_valid_d = 1'b0;
                        tap_last_d  = 1'b0;
                        busy_d      = 1'b0;
                        din_ready_d = 1'b1;
                    end else begin
                        tap_idx_d  = next_k_s;
                        tap_data_d = rd_data_s;
                        tap_last_d = (next_k_s == LAST_K);
                    end
                end else begin
                    state_d = ST_SEQ;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                tap_valid_d = 1'b0;
                tap_last_d  = 1'b0;
                busy_d      = 1'b0;
                din_ready_d = 1'b0;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= {IW{1'b0}};
            rd_ptr_q    <= {IW{1'b0}};
            fill_q      <= {FW{1'b0}};
            tap_data_q  <= {dsize{1'b0}};
            tap_idx_q   <= {IW{1'b0}};
            tap_valid_q <= 1'b0;
            tap_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            din_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            tap_data_q  <= tap_data_d;
            tap_idx_q   <= tap_idx_d;
            tap_valid_q <= tap_valid_d;
            tap_last_q  <= tap_last_d;
            busy_q      <= busy_d;
            din_ready_q <= din_ready_d;
        end
    end

    // Sample storage, cleared on reset so nothing stale survives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < nbtap; i++) begin
                buf_q[i] <= {dsize{1'b0}};
            end
        end else if (wr_en_s) begin
            buf_q[wr_ptr_q] <= datain;
        end else begin
            buf_q <= buf_q;
        end
    end

    assign din_ready = din_ready_q;
    assign tap_data  = tap_data_q;
    assign tap_idx   = tap_idx_q;
    assign tap_valid = tap_valid_q;
    assign tap_last  = tap_last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sfir_tap_sequencer.sv
// Directed self-checking bench for sfir_tap_sequencer (dsize=16, nbtap=4),
// covering both the default and SFIR_TAP_REVERSE_EN tap orders.
module tb_sfir_tap_sequencer;

    logic        clk;
    logic        rst_n;
    logic [15:0] datain;
    logic        din_valid;
    logic        din_ready;
    logic [15:0] tap_data;
    logic [1:0]  tap_idx;
    logic        tap_valid;
    logic        tap_ready;
    logic        tap_last;
    logic        busy;

    int checks = 0;
    int errors = 0;

`ifdef SFIR_TAP_REVERSE_EN
    localparam bit REV = 1'b1;
`else
    localparam bit REV = 1'b0;
`endif

    sfir_tap_sequencer #(.dsize(16), .nbtap(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .datain    (datain),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .tap_data  (tap_data),
        .tap_idx   (tap_idx),
        .tap_valid (tap_valid),
        .tap_ready (tap_ready),
        .tap_last  (tap_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tap index presented at step j of a sequence
    function automatic int kmap(input int j);
        return REV ? (3 - j) : j;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_tap(input string tag, input int j, input logic [15:0] e [4]);
        int k;
        k = kmap(j);
        chk({tag, "_valid"}, 32'(tap_valid), 32'd1);
        chk({tag, "_idx"},   32'(tap_idx),   32'(k));
        chk({tag, "_data"},  32'(tap_data),  32'(e[k]));
        chk({tag, "_last"},  32'(tap_last),  (j == 3) ? 32'd1 : 32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd1);
        chk({tag, "_dready"}, 32'(din_ready), 32'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"},  32'(tap_valid), 32'd0);
        chk({tag, "_busy"},   32'(busy),      32'd0);
        chk({tag, "_dready"}, 32'(din_ready), 32'd1);
    endtask

    // Offer sample s, then check the full sequence (e indexed by k, newest first)
    task automatic run_seq(input logic [15:0] s, input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3);
        logic [15:0] e [4];
        int n;
        e = '{e0, e1, e2, e3};
        n = 0;
        @(negedge clk);
        din_valid = 1'b1;
        datain    = s;
        tap_ready = 1'b1;
        while (!din_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("seq_wait_ready", 32'(din_ready), 32'd1);
        @(posedge clk); #1;
        for (int j = 0; j < 4; j++) begin
            chk_tap($sformatf("seq%0h_s%0d", s, j), j, e);
            @(negedge clk);
            din_valid = 1'b0;
            @(posedge clk); #1;
        end
        chk_idle($sformatf("seq%0h_end", s));
    endtask

    typedef struct {
        logic        dv;
        logic [15:0] d;
        logic        tr;
        logic        exp_tv;
        int          exp_step;
    } vec_t;

    vec_t        vecs [9];
    logic [15:0] seq40 [4];

    initial begin
        rst_n     = 1'b1;
        din_valid = 1'b0;
        datain    = 16'h0000;
        tap_ready = 1'b0;

        // Stall/ignore-while-busy vectors for the sequence started by sample 0x40
        vecs[0] = '{1'b1, 16'h0040, 1'b1, 1'b1, 0};
        vecs[1] = '{1'b1, 16'h0077, 1'b1, 1'b1, 1};
        vecs[2] = '{1'b1, 16'h0088, 1'b0, 1'b1, 1};
        vecs[3] = '{1'b1, 16'h0088, 1'b0, 1'b1, 1};
        vecs[4] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1};
        vecs[5] = '{1'b0, 16'h0000, 1'b1, 1'b1, 2};
        vecs[6] = '{1'b0, 16'h0000, 1'b1, 1'b1, 3};
        vecs[7] = '{1'b1, 16'h0099, 1'b1, 1'b0, -1};
        vecs[8] = '{1'b0, 16'h0000, 1'b1, 1'b0, -1};
        seq40   = '{16'h0040, 16'h0030, 16'h0020, 16'h0010};

        #2 rst_n = 1'b0;
        #1;
        chk("rst_tap_valid", 32'(tap_valid), 32'd0);
        chk("rst_tap_data",  32'(tap_data),  32'd0);
        chk("rst_tap_idx",   32'(tap_idx),   32'd0);
        chk("rst_tap_last",  32'(tap_last),  32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_din_ready", 32'(din_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("din_ready_after_release", 32'(din_ready), 32'd1);

        run_seq(16'h0011, 16'h0011, 16'h0000, 16'h0000, 16'h0000);
        run_seq(16'h0001, 16'h0001, 16'h0011, 16'h0000, 16'h0000);
        run_seq(16'h0002, 16'h0002, 16'h0001, 16'h0011, 16'h0000);
        run_seq(16'h0003, 16'h0003, 16'h0002, 16'h0001, 16'h0011);
        run_seq(16'h0004, 16'h0004, 16'h0003, 16'h0002, 16'h0001);
        run_seq(16'h0005, 16'h0005, 16'h0004, 16'h0003, 16'h0002);
        run_seq(16'h0010, 16'h0010, 16'h0005, 16'h0004, 16'h0003);
        run_seq(16'h0020, 16'h0020, 16'h0010, 16'h0005, 16'h0004);
        run_seq(16'h0030, 16'h0030, 16'h0020, 16'h0010, 16'h0005);

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            din_valid = vecs[i].dv;
            datain    = vecs[i].d;
            tap_ready = vecs[i].tr;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_valid", i), 32'(tap_valid), 32'(vecs[i].exp_tv));
            if (vecs[i].exp_step >= 0) begin
                chk_tap($sformatf("vec%0d", i), vecs[i].exp_step, seq40);
            end else begin
                chk_idle($sformatf("vec%0d", i));
            end
        end

        // Writes attempted while busy must not have landed in the buffer
        run_seq(16'h0055, 16'h0055, 16'h0040, 16'h0030, 16'h0020);

        // Reset in the middle of a sequence
        @(negedge clk);
        din_valid = 1'b1;
        datain    = 16'h0066;
        tap_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        din_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midrst_pre_idx", 32'(tap_idx), 32'(kmap(2)));
        rst_n = 1'b0;
        #1;
        chk("midrst_tap_valid", 32'(tap_valid), 32'd0);
        chk("midrst_busy",      32'(busy),      32'd0);
        chk("midrst_tap_last",  32'(tap_last),  32'd0);
        chk("midrst_tap_data",  32'(tap_data),  32'd0);
        chk("midrst_din_ready", 32'(din_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_seq(16'h00AA, 16'h00AA, 16'h0000, 16'h0000, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
